// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: hazard, flush, forwarding and boot sequencing for a 5-stage RV32I pipeline
module pipeline_ctrl #(
   parameter int BOOT_CYCLES = 2,
   parameter int CNT_W       = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       id_rs1_addr,
   input  logic [4:0]       id_rs2_addr,
   input  logic [4:0]       id_rd_addr,
   input  logic [1:0]       id_rs1_sel,
   input  logic [1:0]       id_rs2_sel,
   input  logic             id_mem_wen,
   input  logic [1:0]       id_wb_sel,
   input  logic [2:0]       id_br,
   input  logic             ex_br_taken,
   input  logic             mem_busy,
   output logic             pc_we,
   output logic             if_id_we,
   output logic             if_id_flush,
   output logic             id_ex_we,
   output logic             id_ex_flush,
   output logic             ex_mem_we,
   output logic             mem_wb_we,
   output logic [1:0]       fwd_a,
   output logic [1:0]       fwd_b,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);
   localparam logic [1:0] RS1_RS1 = 2'd1;
   localparam logic [1:0] RS2_RS2 = 2'd1;
   localparam logic [1:0] WB_X    = 2'd0;
   localparam logic [1:0] WB_MEM  = 2'd2;
   localparam logic [2:0] BR_X    = 3'd0;
   localparam logic [2:0] BR_JAL  = 3'd1;
   localparam int         BW      = $clog2(BOOT_CYCLES + 1);

   typedef enum logic {BOOT, RUN} state_t;
   state_t          state;
   logic [BW-1:0]   boot_cnt;
   logic            br_pend;
   logic            id_valid, ex_valid, mem_valid, wb_valid;
   logic [4:0]      ex_rd, mem_rd, wb_rd, ex_rs1, ex_rs2;
   logic [1:0]      ex_wb_sel, mem_wb_sel, wb_sel;
   logic            ex_use1, ex_use2;
   logic            run, cond_br, use1, use2, ex_wr, mem_wr, wb_wr;
   logic            taken, load_use, go, do_flush, do_stall, busy, bub;

   always_comb begin
      run      = state == RUN;
      cond_br  = id_br != BR_X && id_br != BR_JAL;
      use1     = id_rs1_sel == RS1_RS1 || cond_br;
      use2     = id_rs2_sel == RS2_RS2 || id_mem_wen || cond_br;
      ex_wr    = ex_valid && ex_wb_sel != WB_X && ex_rd != 5'd0;
      mem_wr   = mem_valid && mem_wb_sel != WB_X && mem_rd != 5'd0;
      wb_wr    = wb_valid && wb_sel != WB_X && wb_rd != 5'd0;
      taken    = ex_valid && (ex_br_taken || br_pend);
      load_use = id_valid && ex_wr && ex_wb_sel == WB_MEM &&
                 ((use1 && id_rs1_addr == ex_rd) || (use2 && id_rs2_addr == ex_rd));
      busy     = run && mem_busy;
      go       = run && !mem_busy;
      do_flush = go && taken;
      do_stall = go && !taken && load_use;
      pc_we       = go && !do_stall;
      if_id_we    = go && !do_stall;
      if_id_flush = do_flush;
      id_ex_we    = go;
      id_ex_flush = do_flush || do_stall;
      ex_mem_we   = go;
      mem_wb_we   = go;
      bub      = id_ex_flush || !id_valid;
      // MEM-stage loads are not forwardable; the load-use stall pushes them to WB first
      fwd_a = !ex_use1 ? 2'b00 :
              (mem_wr && mem_wb_sel != WB_MEM && mem_rd == ex_rs1) ? 2'b01 :
              (wb_wr && wb_rd == ex_rs1) ? 2'b10 : 2'b00;
      fwd_b = !ex_use2 ? 2'b00 :
              (mem_wr && mem_wb_sel != WB_MEM && mem_rd == ex_rs2) ? 2'b01 :
              (wb_wr && wb_rd == ex_rs2) ? 2'b10 : 2'b00;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= BOOT;
         boot_cnt   <= '0;
         br_pend    <= 1'b0;
         id_valid   <= 1'b0;
         ex_valid   <= 1'b0;
         mem_valid  <= 1'b0;
         wb_valid   <= 1'b0;
         ex_rd      <= '0;
         mem_rd     <= '0;
         wb_rd      <= '0;
         ex_rs1     <= '0;
         ex_rs2     <= '0;
         ex_use1    <= 1'b0;
         ex_use2    <= 1'b0;
         ex_wb_sel  <= WB_X;
         mem_wb_sel <= WB_X;
         wb_sel     <= WB_X;
         stall_cnt  <= '0;
         flush_cnt  <= '0;
      end else begin
         if (state == BOOT) begin
            if (boot_cnt == BW'(BOOT_CYCLES - 1)) state <= RUN;
            else boot_cnt <= boot_cnt + BW'(1);
         end
         br_pend <= busy && (br_pend || (ex_valid && ex_br_taken));
         if (if_id_we) id_valid <= !if_id_flush;
         if (id_ex_we) begin
            ex_valid  <= !bub;
            ex_rd     <= bub ? 5'd0 : id_rd_addr;
            ex_wb_sel <= bub ? WB_X : id_wb_sel;
            ex_rs1    <= id_rs1_addr;
            ex_rs2    <= id_rs2_addr;
            ex_use1   <= !bub && use1;
            ex_use2   <= !bub && use2;
         end
         if (ex_mem_we) begin
            mem_valid  <= ex_valid;
            mem_rd     <= ex_rd;
            mem_wb_sel <= ex_wb_sel;
         end
         if (mem_wb_we) begin
            wb_valid <= mem_valid;
            wb_rd    <= mem_rd;
            wb_sel   <= mem_wb_sel;
         end
         if ((busy || do_stall) && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
         if (do_flush && flush_cnt != '1) flush_cnt <= flush_cnt + CNT_W'(1);
      end
   end
endmodule
